// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and constants for the serial CRC checker
// Contents: FSM state enum, default frame geometry, error-counter width.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int WCODE_DEF = 5;   // data bits per frame
   localparam int WPOLY_DEF = 4;   // generator width, degree WPOLY-1
   localparam int ERRCNT_W  = 8;   // width of the optional error counter

endpackage

// File: rtl/crc_lfsr_step.sv
// rtl/crc_lfsr_step.sv - one-bit GF(2) long-division step
// Ports:
//   rem      in  WPOLY-1  current partial remainder
//   bit_in   in  1        next dividend bit
//   poly     in  WPOLY-1  generator polynomial without its implied top bit
//   rem_next out WPOLY-1  partial remainder after absorbing bit_in
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int WPOLY = WPOLY_DEF
) (
   input  logic [WPOLY-2:0] rem,
   input  logic             bit_in,
   input  logic [WPOLY-2:0] poly,
   output logic [WPOLY-2:0] rem_next
);

   // The bit leaving the top of rem is the quotient bit; when set, the
   // generator is subtracted (XOR) from the shifted remainder.
   assign rem_next = {rem[WPOLY-3:0], bit_in} ^ (rem[WPOLY-2] ? poly : '0);

endmodule

// File: rtl/crc_check.sv
// rtl/crc_check.sv - serial CRC checker, MSB-first codeword with valid/ready
// Optional feature macro: CRC_CHECK_ERRCNT_EN (adds o_err_cnt).
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid, i_bit       serial codeword bit and its qualifier
//   i_sof                marks i_bit as bit 0 of a frame
//   i_poly               generator polynomial, top bit implied
//   o_ready              a bit is accepted this cycle when i_valid is high
//   o_valid              one-cycle pulse when results are updated
//   o_data, o_syndrome   data field and remainder of the last frame
//   o_err                syndrome is non-zero
//   o_err_cnt            saturating count of erroneous frames (macro only)
module crc_check
   import crc_pkg::*;
#(
   parameter int WCODE = WCODE_DEF,
   parameter int WPOLY = WPOLY_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   input  logic                i_bit,
   input  logic                i_sof,
   input  logic [WPOLY-1:0]    i_poly,
   output logic                o_ready,
   output logic                o_valid,
   output logic [WCODE-1:0]    o_data,
   output logic [WPOLY-2:0]    o_syndrome,
   output logic                o_err
`ifdef CRC_CHECK_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0] o_err_cnt
`endif
);

   localparam int WCRC  = WPOLY - 1;
   localparam int LEN   = WCODE + WCRC;
   localparam int CNT_W = $clog2(LEN);

   state_t            state, state_next;
   logic [CNT_W-1:0]  idx;        // index of the next bit within the frame
   logic [WCRC-1:0]   rem;
   logic [WCRC-1:0]   poly_lat;
   logic [WCODE-1:0]  data_sr;
   logic [WCRC-1:0]   step_rem;
   logic [WCRC-1:0]   rem_next;
   logic              accept;
   logic              frame_start;
   logic              last_bit;
   logic              unused_poly_msb;

   assign unused_poly_msb = i_poly[WPOLY-1];

   assign o_ready     = (state != DONE);
   assign o_valid     = (state == DONE);
   assign accept      = i_valid && o_ready;
   assign frame_start = accept && i_sof;
   assign last_bit    = accept && !i_sof && (state == SHIFT) && (idx == CNT_W'(LEN - 1));

   // A starting frame divides from a zero remainder, so the feedback bit is
   // zero and the not-yet-latched polynomial cannot influence the result.
   assign step_rem = frame_start ? '0 : rem;

   crc_lfsr_step #(.WPOLY(WPOLY)) u_step (
      .rem      (step_rem),
      .bit_in   (i_bit),
      .poly     (poly_lat),
      .rem_next (rem_next)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (frame_start) state_next = SHIFT;
         SHIFT:   if (last_bit)    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx        <= '0;
         rem        <= '0;
         poly_lat   <= '0;
         data_sr    <= '0;
         o_data     <= '0;
         o_syndrome <= '0;
         o_err      <= 1'b0;
      end else if (frame_start) begin
         // Also covers a restart in the middle of a frame.
         poly_lat <= i_poly[WCRC-1:0];
         rem      <= rem_next;
         idx      <= CNT_W'(1);
         data_sr  <= {{(WCODE-1){1'b0}}, i_bit};
      end else if (accept && (state == SHIFT)) begin
         rem <= rem_next;
         idx <= idx + CNT_W'(1);
         if (idx < CNT_W'(WCODE))
            data_sr <= {data_sr[WCODE-2:0], i_bit};
         if (last_bit) begin
            o_data     <= data_sr;
            o_syndrome <= rem_next;
            o_err      <= |rem_next;
         end
      end
   end

`ifdef CRC_CHECK_ERRCNT_EN
   // o_err is already the new frame's flag while in DONE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_err_cnt <= '0;
      else if ((state == DONE) && o_err && (o_err_cnt != '1))
         o_err_cnt <= o_err_cnt + ERRCNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_crc_check.sv
// tb/tb_crc_check.sv - self-checking bench for crc_check
module tb_crc_check;

   localparam int WCODE = 5;
   localparam int WPOLY = 4;
   localparam int WCRC  = WPOLY - 1;
   localparam int LEN   = WCODE + WCRC;

   // 11001 under x^3+x+1 carries check bits 111.
   localparam logic [LEN-1:0] CW_CLEAN = 8'b11001_111;
   localparam logic [LEN-1:0] CW_BIT3  = 8'b11000_111;   // syndrome 011
   localparam logic [LEN-1:0] CW_LAST  = 8'b11001_110;   // syndrome 001
   localparam logic [LEN-1:0] CW_P1101 = 8'b10110_000;   // syndrome 101 under 1101

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_valid, i_bit, i_sof;
   logic [WPOLY-1:0]  i_poly;
   logic              o_ready, o_valid, o_err;
   logic [WCODE-1:0]  o_data;
   logic [WCRC-1:0]   o_syndrome;
`ifdef CRC_CHECK_ERRCNT_EN
   logic [7:0]        o_err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   bit chk_en = 1'b0;

   crc_check #(.WCODE(WCODE), .WPOLY(WPOLY)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (i_valid),
      .i_bit      (i_bit),
      .i_sof      (i_sof),
      .i_poly     (i_poly),
      .o_ready    (o_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_syndrome (o_syndrome),
      .o_err      (o_err)
`ifdef CRC_CHECK_ERRCNT_EN
      ,
      .o_err_cnt  (o_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-codeword polynomial long division.
   function automatic logic [WCRC-1:0] gf2_mod(input logic [LEN-1:0] cw, input logic [WPOLY-1:0] g);
      logic [LEN-1:0] r;
      r = cw;
      for (int i = LEN - 1; i >= WCRC; i--)
         if (r[i]) r = r ^ (LEN'(g) << (i - WCRC));
      return r[WCRC-1:0];
   endfunction

   // ---------------- frame-level reference model ----------------
   logic             q[$];
   logic [LEN-1:0]   m_cw;
   logic [WCRC-1:0]  m_poly = '0;
   bit               m_in_frame = 1'b0;
   bit               m_done = 1'b0;
   logic [WCODE-1:0] m_data = '0;
   logic [WCRC-1:0]  m_syn = '0;
   logic             m_err = 1'b0;
   int               m_errcnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_in_frame = 1'b0;
         m_done     = 1'b0;
         m_data     = '0;
         m_syn      = '0;
         m_err      = 1'b0;
         m_errcnt   = 0;
      end else if (m_done) begin
         // result cycle: nothing is taken from the link
         m_done = 1'b0;
         if (m_err && m_errcnt < 255) m_errcnt++;
      end else if (i_valid) begin
         if (i_sof) begin
            q.delete();
            q.push_back(i_bit);
            m_poly     = i_poly[WCRC-1:0];
            m_in_frame = 1'b1;
         end else if (m_in_frame) begin
            q.push_back(i_bit);
         end
         if (m_in_frame && q.size() == LEN) begin
            for (int i = 0; i < LEN; i++) m_cw[LEN-1-i] = q[i];
            m_data     = m_cw[LEN-1 -: WCODE];
            m_syn      = gf2_mod(m_cw, {1'b1, m_poly});
            m_err      = (m_syn != '0);
            m_done     = 1'b1;
            m_in_frame = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", o_ready, !m_done);
         chk("valid", o_valid, m_done);
         chk("data", o_data, m_data);
         chk("syndrome", o_syndrome, m_syn);
         chk("err", o_err, m_err);
`ifdef CRC_CHECK_ERRCNT_EN
         chk("err_cnt", o_err_cnt, m_errcnt);
`endif
         if (o_valid) valid_cnt++;
      end
   end

   // ---------------- driver ----------------
   // Called at a negedge; returns at the negedge after the bit was taken.
   task automatic send_bit(input logic b, input logic sof);
      int guard;
      guard   = 0;
      i_valid = 1'b1;
      i_bit   = b;
      i_sof   = sof;
      while (!o_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: o_ready stayed %0b, required 1", o_ready);
      end
      @(negedge clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [LEN-1:0] cw, input logic [WPOLY-1:0] poly,
                             input logic [WPOLY-1:0] poly_after, input bit gaps);
      i_poly = poly;
      for (int i = LEN - 1; i >= 0; i--) begin
         send_bit(cw[i], (i == LEN - 1));
         if (i == LEN - 1) i_poly = poly_after;
         if (gaps && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic lit_result(input string name, input logic [WCODE-1:0] d,
                             input logic [WCRC-1:0] s, input logic e);
      chk({name, "_valid"}, o_valid, 1'b1);
      chk({name, "_data"}, o_data, d);
      chk({name, "_syn"}, o_syndrome, s);
      chk({name, "_err"}, o_err, e);
   endtask

   int v0;

   initial begin
      rst_n   = 1'b1;
      i_valid = 1'b0;
      i_bit   = 1'b0;
      i_sof   = 1'b0;
      i_poly  = 4'b1011;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, 5'b0);
      chk("rst_syn", o_syndrome, 3'b0);
      chk("rst_err", o_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // clean frame, back to back; result in the cycle after the 8th bit
      send_frame(CW_CLEAN, 4'b1011, 4'b1011, 1'b0);
      lit_result("clean", 5'b11001, 3'b000, 1'b0);
      @(negedge clk);
      chk("valid_one_cycle", o_valid, 1'b0);
      chk("data_hold", o_data, 5'b11001);

      // error in the last check bit, then in data bit 3
      send_frame(CW_LAST, 4'b1011, 4'b1011, 1'b0);
      lit_result("last_bit", 5'b11001, 3'b001, 1'b1);
      send_frame(CW_BIT3, 4'b1011, 4'b1011, 1'b0);
      lit_result("bit3", 5'b11000, 3'b011, 1'b1);
      @(negedge clk);
`ifdef CRC_CHECK_ERRCNT_EN
      chk("errcnt_two", o_err_cnt, 8'd2);
`endif

      // polynomial top bit ignored; polynomial latched at sof
      send_frame(CW_CLEAN, 4'b0011, 4'b0011, 1'b0);
      lit_result("poly_msb", 5'b11001, 3'b000, 1'b0);
      send_frame(CW_CLEAN, 4'b1011, 4'b1101, 1'b0);
      lit_result("poly_latch", 5'b11001, 3'b000, 1'b0);
      send_frame(CW_P1101, 4'b1101, 4'b1011, 1'b0);
      lit_result("poly_1101", 5'b10110, 3'b101, 1'b1);

      // gaps, then a sof offered during the result cycle
      send_frame(CW_CLEAN, 4'b1011, 4'b1011, 1'b1);
      lit_result("gaps", 5'b11001, 3'b000, 1'b0);
      chk("done_not_ready", o_ready, 1'b0);
      send_frame(CW_CLEAN, 4'b1011, 4'b1011, 1'b0);
      lit_result("after_done", 5'b11001, 3'b000, 1'b0);
      @(negedge clk);

      // abort: 4 bits of a bad frame, then a fresh clean one
      v0 = valid_cnt;
      for (int i = LEN - 1; i >= LEN - 4; i--) send_bit(CW_BIT3[i], (i == LEN - 1));
      send_frame(CW_CLEAN, 4'b1011, 4'b1011, 1'b0);
      lit_result("abort", 5'b11001, 3'b000, 1'b0);
      @(negedge clk);
      chk("abort_one_valid", valid_cnt - v0, 1);

      // reset in the middle of a frame, after a failing result
      send_frame(CW_BIT3, 4'b1011, 4'b1011, 1'b0);
      @(negedge clk);
      for (int i = LEN - 1; i >= LEN - 5; i--) send_bit(CW_CLEAN[i], (i == LEN - 1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", o_ready, 1'b1);
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_data", o_data, 5'b0);
      chk("mid_rst_syn", o_syndrome, 3'b0);
      chk("mid_rst_err", o_err, 1'b0);
`ifdef CRC_CHECK_ERRCNT_EN
      chk("mid_rst_errcnt", o_err_cnt, 8'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(CW_CLEAN, 4'b1011, 4'b1011, 1'b0);
      lit_result("post_rst", 5'b11001, 3'b000, 1'b0);

      // many corrupted frames: counter saturation
      for (int n = 0; n < 260; n++) send_frame(CW_BIT3, 4'b1011, 4'b1011, 1'b0);
      lit_result("burst", 5'b11000, 3'b011, 1'b1);
      repeat (2) @(negedge clk);
`ifdef CRC_CHECK_ERRCNT_EN
      chk("errcnt_sat", o_err_cnt, 8'hFF);
`endif

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
